mul32_seq_ctrl: RTL and testbench

MUL32_SEQ_CTRL -- requirements
Module: mul32_seq_ctrl

---
 rtl/mul_pkg.sv | 34 +++
 rtl/dadda_16x16_uncompressed.sv | 31 +++
 rtl/mul32_seq_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_mul32_seq_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg
// Shared definitions for the sequential 32x32 multiplier controller:
// operand/product widths, FSM state encoding, step index type and the
// per-step shift lookup.
package mul_pkg;

    localparam int OP_W   = 32;
    localparam int HALF_W = 16;
    localparam int PROD_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mul_state_e;

    // Step index: bit 1 selects the a half, bit 0 selects the b half.
    typedef logic [1:0] step_t;

    // Left shift applied to the 16x16 partial product of a given step.
    function automatic logic [5:0] step_shift(input step_t step);
        logic [5:0] sh;
        case (step)
            2'd0:    sh = 6'd0;
            2'd1:    sh = 6'd16;
            2'd2:    sh = 6'd16;
            2'd3:    sh = 6'd32;
            default: sh = 6'd0;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/dadda_16x16_uncompressed.sv
// dadda_16x16_uncompressed
// Combinational 16x16 unsigned multiplier. The partial-product array is
// summed directly (no explicit compression tree); synthesis maps the adds.
// Ports:
//   a, b : 16-bit unsigned operands
//   p    : 32-bit unsigned product
module dadda_16x16_uncompressed
    import mul_pkg::*;
(
    input  logic [HALF_W-1:0]   a,
    input  logic [HALF_W-1:0]   b,
    output logic [2*HALF_W-1:0] p
);

    logic [2*HALF_W-1:0] sum_s;

    // Sum of the sixteen shifted partial products selected by b.
    always_comb begin
        sum_s = 32'd0;
        for (int i = 0; i < HALF_W; i++) begin
            if (b[i]) begin
                sum_s = sum_s + ({16'd0, a} << i);
            end else begin
                sum_s = sum_s;
            end
        end
    end

    assign p = sum_s;

endmodule

// File: rtl/mul32_seq_ctrl.sv
// mul32_seq_ctrl
// Sequential 32x32 unsigned multiplier built around one shared 16x16
// multiplier. Four half-products (lo*lo, lo*hi, hi*lo, hi*hi) are issued in
// consecutive MUL cycles and shift-added into a 64-bit accumulator.
// The half-select mux output is registered in front of the multiplier, so
// MUL runs one extra tail cycle to retire the last step. PIPE=1 adds a
// product register and a DRAIN state.
// Optional feature: define MUL32_MAC_EN to add in_acc, which seeds the
// accumulator with the previous out_p (multiply-accumulate).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : operand handshake (ready only in IDLE)
//   in_a, in_b          : 32-bit unsigned operands
//   in_acc              : accumulate request (MUL32_MAC_EN only)
//   out_valid/out_ready : result handshake (valid only in DONE)
//   out_p               : 64-bit product, retained after DONE
//   busy                : high whenever the FSM is not IDLE
module mul32_seq_ctrl
    import mul_pkg::*;
#(
    parameter int PIPE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
`ifdef MUL32_MAC_EN
    input  logic              in_acc,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_p,
    output logic              busy
);

    mul_state_e          state_q, state_d;
    step_t               step_q, step_d;
    logic                tail_q, tail_d;
    logic [OP_W-1:0]     a_q, a_d, b_q, b_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [HALF_W-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [5:0]          sh_q, sh_d, psh_q, psh_d;
    logic                sv_q, sv_d, pv_q, pv_d;
    logic [2*HALF_W-1:0] prod_s, pprod_q, pprod_d;
    logic                out_valid_q, out_valid_d, in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic [PROD_W-1:0]   out_p_q, out_p_d, seed_s;
    logic                accept_s, add_v_s;
    logic [2*HALF_W-1:0] add_p_s;
    logic [5:0]          add_sh_s;

    dadda_16x16_uncompressed u_mul (
        .a (mul_a_q),
        .b (mul_b_q),
        .p (prod_s)
    );

    assign accept_s = in_valid && in_ready_q;

`ifdef MUL32_MAC_EN
    assign seed_s = in_acc ? out_p_q : 64'd0;
`else
    assign seed_s = 64'd0;
`endif

    // FSM next state; the tail flag marks the MUL cycle retiring step S3.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_MUL;
                else          state_d = ST_IDLE;
            end
            ST_MUL: begin
                if (tail_q) begin
                    if (PIPE != 0) state_d = ST_DRAIN;
                    else           state_d = ST_DONE;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
                else           state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Step sequencing, operand capture, half-select and product staging.
    always_comb begin
        if (state_q == ST_MUL && !tail_q) step_d = step_q + 2'd1;
        else                              step_d = 2'd0;
        tail_d  = (state_q == ST_MUL) && (step_q == 2'd3) && !tail_q;
        if (accept_s) begin
            a_d = in_a;
            b_d = in_b;
        end else begin
            a_d = a_q;
            b_d = b_q;
        end
        mul_a_d = step_q[1] ? a_q[31:16] : a_q[15:0];
        mul_b_d = step_q[0] ? b_q[31:16] : b_q[15:0];
        sh_d    = step_shift(step_q);
        sv_d    = (state_q == ST_MUL) && !tail_q;
        pv_d    = sv_q;
        pprod_d = prod_s;
        psh_d   = sh_q;
    end

    // Accumulator: seed on acceptance, then add each retired shifted step.
    always_comb begin
        if (PIPE != 0) begin
            add_v_s  = pv_q;
            add_p_s  = pprod_q;
            add_sh_s = psh_q;
        end else begin
            add_v_s  = sv_q;
            add_p_s  = prod_s;
            add_sh_s = sh_q;
        end
        if (accept_s)     acc_d = seed_s;
        else if (add_v_s) acc_d = acc_q + ({32'd0, add_p_s} << add_sh_s);
        else              acc_d = acc_q;
    end

    // Registered outputs; out_p is loaded on DONE entry and then retained.
    always_comb begin
        out_valid_d = (state_d == ST_DONE);
        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        if (state_q != ST_DONE && state_d == ST_DONE) out_p_d = acc_d;
        else                                          out_p_d = out_p_q;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            step_q      <= 2'd0;
            tail_q      <= 1'b0;
            a_q         <= 32'd0;
            b_q         <= 32'd0;
            acc_q       <= 64'd0;
            mul_a_q     <= 16'd0;
            mul_b_q     <= 16'd0;
            sh_q        <= 6'd0;
            sv_q        <= 1'b0;
            pv_q        <= 1'b0;
            pprod_q     <= 32'd0;
            psh_q       <= 6'd0;
            out_valid_q <= 1'b0;
            out_p_q     <= 64'd0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            tail_q      <= tail_d;
            a_q         <= a_d;
            b_q         <= b_d;
            acc_q       <= acc_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            sh_q        <= sh_d;
            sv_q        <= sv_d;
            pv_q        <= pv_d;
            pprod_q     <= pprod_d;
            psh_q       <= psh_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mul32_seq_ctrl.sv
// tb_mul32_seq_ctrl
// Directed bench driving a PIPE=0 and a PIPE=1 instance with the same
// stimulus; expected products and latencies are hand-computed constants.
module tb_mul32_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_a, in_b;
    logic        out_ready;
`ifdef MUL32_MAC_EN
    logic        in_acc;
`endif
    logic        rdy0, rdy1, v0, v1, busy0, busy1;
    logic [63:0] p0, p1;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mul32_seq_ctrl #(.PIPE(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .in_a(in_a), .in_b(in_b),
`ifdef MUL32_MAC_EN
        .in_acc(in_acc),
`endif
        .out_valid(v0), .out_ready(out_ready), .out_p(p0), .busy(busy0)
    );

    mul32_seq_ctrl #(.PIPE(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .in_a(in_a), .in_b(in_b),
`ifdef MUL32_MAC_EN
        .in_acc(in_acc),
`endif
        .out_valid(v1), .out_ready(out_ready), .out_p(p1), .busy(busy1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!(rdy0 && rdy1) && n < 50) begin
            step();
            n++;
        end
        chk("ready_wait", 64'(rdy0 && rdy1), 64'd1);
    endtask

    // One operation with out_ready=1; checks latency edges T+4..T+7.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic acc, input logic [63:0] exp, input logic scramble);
        wait_ready();
        in_a = a;
        in_b = b;
`ifdef MUL32_MAC_EN
        in_acc = acc;
`else
        if (acc) $display("note: in_acc ignored in this build (%s)", tag);
`endif
        in_valid = 1'b1;
        step();                      // acceptance edge T
        in_valid = 1'b0;
        if (scramble) begin
            in_a = 32'd0;
            in_b = 32'd0;
        end
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 4) chk({tag, "_v0_t4"}, 64'(v0), 64'd0);
            if (k == 5) begin
                chk({tag, "_v0_t5"}, 64'(v0), 64'd1);
                chk({tag, "_p0"}, p0, exp);
                chk({tag, "_v1_t5"}, 64'(v1), 64'd0);
            end
            if (k == 6) begin
                chk({tag, "_v0_t6"}, 64'(v0), 64'd0);
                chk({tag, "_v1_t6"}, 64'(v1), 64'd1);
                chk({tag, "_p1"}, p1, exp);
            end
            if (k == 7) chk({tag, "_v1_t7"}, 64'(v1), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; out_ready = 1'b1;
`ifdef MUL32_MAC_EN
        in_acc = 1'b0;
`endif
        step();
        step();
        chk("rst_v0", 64'(v0), 64'd0);
        chk("rst_v1", 64'(v1), 64'd0);
        chk("rst_p0", p0, 64'd0);
        chk("rst_busy0", 64'(busy0), 64'd0);
        chk("rst_rdy0", 64'(rdy0), 64'd0);
        chk("rst_rdy1", 64'(rdy1), 64'd0);
        rst = 1'b0;
        step();
        chk("post_rst_rdy0", 64'(rdy0), 64'd1);
        chk("post_rst_rdy1", 64'(rdy1), 64'd1);

        run_op("basic", 32'h00012345, 32'h00010000, 1'b0, 64'h0000000123450000, 1'b0);
        run_op("maxval", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 1'b0);

        // Backpressure: hold DONE for 10 cycles, in_valid pulses ignored.
        wait_ready();
        out_ready = 1'b0;
        in_a = 32'h00001000; in_b = 32'h00000003; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) step();
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            in_a = 32'hDEAD0000 + 32'(i);
            step();
            chk("hold_v0", 64'(v0), 64'd1);
            chk("hold_v1", 64'(v1), 64'd1);
            chk("hold_p0", p0, 64'h3000);
            chk("hold_p1", p1, 64'h3000);
            chk("hold_rdy", 64'(rdy0 || rdy1), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("release_v0", 64'(v0), 64'd0);
        chk("release_v1", 64'(v1), 64'd0);
        chk("release_busy", 64'(busy0 || busy1), 64'd0);

        // Reset during step S2 aborts the operation.
        wait_ready();
        in_a = 32'h12345678; in_b = 32'h9ABCDEF0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("abort_v0", 64'(v0), 64'd0);
        chk("abort_v1", 64'(v1), 64'd0);
        chk("abort_p0", p0, 64'd0);
        chk("abort_p1", p1, 64'd0);
        chk("abort_busy", 64'(busy0 || busy1), 64'd0);
        rst = 1'b0;
        step();
        chk("abort_rdy", 64'(rdy0 && rdy1), 64'd1);
        run_op("after_abort", 32'd3, 32'd5, 1'b0, 64'd15, 1'b0);

        run_op("toggle", 32'd7, 32'd9, 1'b0, 64'd63, 1'b1);

`ifdef MUL32_MAC_EN
        run_op("mac0", 32'd2, 32'd3, 1'b0, 64'd6, 1'b0);
        run_op("mac1", 32'd4, 32'd5, 1'b1, 64'd26, 1'b0);
        run_op("mac_wrap", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'hFFFFFFFE0000001B, 1'b0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
